// File: rtl/demux4_dispatcher_pkg.sv
// Shared constants and types for the 4-channel dispatcher.
package demux4_dispatcher_pkg;

    localparam int unsigned NCH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } state_t;

    typedef enum logic {
        RR    = 1'b0,
        FIXED = 1'b1
    } mode_t;

endpackage

// File: rtl/demux4_dispatcher_rr_pick4.sv
// Rotating first-ready search: scans req starting at ptr, wrapping mod 4.
module rr_pick4
    import demux4_dispatcher_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     ptr,
    output logic [1:0]     grant_idx,
    output logic           any
);

    logic [1:0] idx;

    // First requesting channel at or after ptr, in rotating order
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = ptr + 2'(i);
            if (!any && req[idx]) begin
                grant_idx = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux4_dispatcher.sv
// One-word holding register dispatched to one of four output channels,
// chosen round-robin over ready channels or fixed by cfg_ch.
module demux4_dispatcher
    import demux4_dispatcher_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [1:0]    cfg_ch,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out0,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [3:0]    out_valid,
    output logic [1:0]    sel,
    output logic [7:0]    disp_cnt
);

    state_t                   state;
    logic [DW-1:0]            hold;
    logic [1:0]               ptr;
    logic [NCH-1:0][DW-1:0]   outs_r;

    logic [1:0]               rr_idx;
    logic                     rr_any;
    logic [1:0]               pick;
    logic                     elig;
    logic                     dispatch_now;
    logic                     accept;

    rr_pick4 u_pick (
        .req       (out_ready),
        .ptr       (ptr),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Channel selection for the current arbitration, per active mode
    always_comb begin
        pick = rr_idx;
        elig = rr_any;
        if (mode_t'(mode) == FIXED) begin
            pick = cfg_ch;
            elig = out_ready[cfg_ch];
        end
    end

    // Handshake: a dispatch frees the register in the same cycle, so a new
    // word may be taken while the old one leaves (out_ready -> in_ready path)
    always_comb begin
        dispatch_now = (state == PEND) && elig;
        in_ready     = rst_n && ((state == EMPTY) || dispatch_now);
        accept       = in_valid && in_ready;
    end

    assign out0 = outs_r[0];
    assign out1 = outs_r[1];
    assign out2 = outs_r[2];
    assign out3 = outs_r[3];

    // FSM, holding register and registered channel outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            hold      <= '0;
            ptr       <= '0;
            sel       <= '0;
            disp_cnt  <= '0;
            out_valid <= '0;
            outs_r    <= '0;
        end else begin
            out_valid <= '0;
            outs_r    <= '0;
            if (dispatch_now) begin
                out_valid    <= 4'b0001 << pick;
                outs_r[pick] <= hold;
                sel          <= pick;
                disp_cnt     <= disp_cnt + 8'd1;
                if (mode_t'(mode) == RR) begin
                    ptr <= pick + 2'd1;
                end
            end
            if (accept) begin
                hold  <= in_data;
                state <= PEND;
            end else if (dispatch_now) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Scoreboard bench for demux4_dispatcher: stimulus process models the
// dispatcher at transaction level and queues expected strobes; a monitor
// process pops and compares whenever out_valid is non-zero.
module tb_demux4_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mode = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [3:0] out_ready = '0;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [1:0] sel;
    logic [7:0] disp_cnt;

    demux4_dispatcher #(.DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .cfg_ch    (cfg_ch),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .sel       (sel),
        .disp_cnt  (disp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned ch;
        logic [3:0]  data;
        int unsigned cnt;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_pend = 0;
    logic [3:0]  m_word = '0;
    int unsigned m_ptr = 0;
    int unsigned m_sel = 0;
    int unsigned m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check registered state and in_ready, advance model
    task automatic cycle(input logic r, input logic v, input logic [3:0] d,
                         input logic m, input logic [1:0] ch, input logic [3:0] ordy);
        bit          found;
        int unsigned c;
        bit          disp;
        bit          exp_rdy;
        exp_t        e;
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; mode = m; cfg_ch = ch; out_ready = ordy;
        #1;
        chk("disp_cnt", 32'(disp_cnt), 32'(m_cnt));
        chk("sel", 32'(sel), 32'(m_sel));
        found = 0;
        c = 0;
        if (m == 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned k;
                k = (m_ptr + i) % 4;
                if (!found && ordy[k]) begin found = 1; c = k; end
            end
        end else if (ordy[ch]) begin
            found = 1;
            c = ch;
        end
        disp = r && m_pend && found;
        exp_rdy = r && (!m_pend || disp);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (!r) begin
            m_pend = 0; m_word = '0; m_ptr = 0; m_sel = 0; m_cnt = 0;
        end else begin
            if (disp) begin
                m_cnt = (m_cnt + 1) % 256;
                e.ch = c; e.data = m_word; e.cnt = m_cnt;
                q.push_back(e);
                m_sel = c;
                if (m == 1'b0) m_ptr = (c + 1) % 4;
                m_pend = 0;
            end
            if (v && exp_rdy) begin
                m_pend = 1;
                m_word = d;
            end
        end
    endtask

    // Monitor: compare every strobe against the head of the scoreboard
    always @(negedge clk) begin
        logic [3:0] o[4];
        o[0] = out0; o[1] = out1; o[2] = out2; o[3] = out3;
        if (out_valid !== 4'b0000 && !$isunknown(out_valid)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got out_valid=%b expected none at %0t", out_valid, $time);
            end else begin
                exp_t e;
                logic [3:0] ev;
                e = q.pop_front();
                ev = 4'b0001 << e.ch;
                chk("out_valid", 32'(out_valid), 32'(ev));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("out%0d", k), 32'(o[k]), (k == int'(e.ch)) ? 32'(e.data) : 32'd0);
                chk("strobe_sel", 32'(sel), 32'(e.ch));
                chk("strobe_cnt", 32'(disp_cnt), 32'(e.cnt));
            end
        end else if ($time > 0) begin
            chk("idle_outs", {16'd0, o[3], o[2], o[1], o[0]}, 32'd0);
        end
    end

    initial begin
        // Reset
        cycle(0, 0, 4'h0, 0, 2'd0, 4'h0);
        cycle(0, 0, 4'h0, 0, 2'd0, 4'hF);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);

        // RR stream 1..5, all channels ready
        for (int i = 1; i <= 5; i++) cycle(1, 1, 4'(i), 0, 2'd0, 4'hF);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);
        chk("stream_cnt5", 32'(disp_cnt), 32'd5);

        // ptr=1, only ch0/ch2 ready: word lands on ch2
        cycle(1, 1, 4'hA, 0, 2'd0, 4'b0101);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'b0101);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'b0101);
        chk("rr_skip_sel", 32'(sel), 32'd2);

        // FIXED ch3 stalled for 10 cycles, then released
        cycle(1, 1, 4'h7, 1, 2'd3, 4'b0111);
        for (int i = 0; i < 10; i++) cycle(1, 0, 4'h0, 1, 2'd3, 4'b0111);
        cycle(1, 0, 4'h0, 1, 2'd3, 4'hF);
        cycle(1, 0, 4'h0, 1, 2'd3, 4'hF);

        // Stall, then release coincides with a new offered word
        cycle(1, 1, 4'h3, 1, 2'd1, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(1, 1, 4'h9, 1, 2'd1, 4'b0000);
        cycle(1, 1, 4'h5, 1, 2'd1, 4'b0010);
        cycle(1, 0, 4'h0, 1, 2'd1, 4'b0010);
        cycle(1, 0, 4'h0, 1, 2'd1, 4'b0010);

        // Reset while holding 0xC
        cycle(1, 1, 4'hC, 1, 2'd2, 4'b0000);
        cycle(1, 0, 4'h0, 1, 2'd2, 4'b0000);
        cycle(0, 0, 4'h0, 1, 2'd2, 4'hF);
        cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);
        chk("post_reset_cnt", 32'(disp_cnt), 32'd0);
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 1)),
                  4'($urandom), logic'($urandom_range(0, 3) == 0),
                  2'($urandom), 4'($urandom));
        end

        // 256 dispatches from zero wrap the counter
        cycle(0, 0, 4'h0, 0, 2'd0, 4'hF);
        for (int i = 0; i < 256; i++) cycle(1, 1, 4'($urandom), 0, 2'd0, 4'hF);
        for (int i = 0; i < 3; i++) cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);
        chk("wrap_cnt", 32'(disp_cnt), 32'd0);

        cycle(1, 0, 4'h0, 0, 2'd0, 4'hF);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux4_dispatcher.md
DEMUX4_DISPATCHER -- requirements
Module: demux4_dispatcher

Interface
REQ-001 Parameter DW, default 4, data word width in bits.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-004 Port in_data, input, DW, word offered by the upstream source.
REQ-005 Port in_valid, input, 1, upstream word present.
REQ-006 Port in_ready, output, 1, dispatcher accepts in_data this cycle.
REQ-007 Port mode, input, 1, selects channel policy: 0 = round-robin, 1 = fixed channel.
REQ-008 Port cfg_ch, input, 2, target channel when mode=1.
REQ-009 Port out_ready, input, 4, bit k high = channel k can take a word this cycle.
REQ-010 Ports out0..out3, output, DW each, registered per-channel data.
REQ-011 Port out_valid, output, 4, registered one-hot-or-zero strobe; bit k qualifies outk.
REQ-012 Port sel, output, 2, channel index of the most recent dispatch.
REQ-013 Port disp_cnt, output, 8, total dispatched words, wraps 255->0.

Function
REQ-014 Holds one word in a holding register; FSM states EMPTY (register free) and PEND (word waiting).
REQ-015 Accept: in_valid & in_ready loads hold; EMPTY->PEND, or PEND stays PEND if a dispatch and an accept occur in the same cycle.
REQ-016 in_ready = (state==EMPTY) | dispatch_now; combinational path from out_ready to in_ready is intended; 1 word/cycle sustained.
REQ-017 Eligible channel, mode=0: first k with out_ready[k]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-018 Eligible channel, mode=1: cfg_ch only if out_ready[cfg_ch]=1; otherwise none.
REQ-019 dispatch_now = (state==PEND) & eligible channel exists.
REQ-020 On dispatch to channel c: next cycle out_valid = one-hot c, outc = hold, all other outk = 0, sel = c, ptr = c+1 mod 4, disp_cnt += 1.
REQ-021 Cycles without dispatch: out_valid = 0, all outk = 0; sel and ptr hold.
REQ-022 Latency: accept at cycle t -> earliest out_valid at t+2.
REQ-023 PEND with no eligible channel: hold, ptr, and sel unchanged; in_ready = 0; waits indefinitely with no drop.
REQ-024 mode, cfg_ch, and out_ready are evaluated every cycle; a change during PEND applies to the next arbitration.
REQ-025 ptr is updated only in mode=0; dispatches in mode=1 leave ptr unchanged but update sel.
REQ-026 Ordering: words leave in acceptance order; never more than one word in flight.

Reset
REQ-027 With rst_n=0 at a clk edge: state=EMPTY, hold=0, ptr=0, sel=0, disp_cnt=0, out_valid=0, out0..out3=0.
REQ-028 Reset mid-PEND discards the held word with no out_valid strobe; in_ready = 1 on the first cycle after release.
REQ-029 in_ready = 0 while rst_n=0.

Structure
REQ-030 A shared constants file holds NCH=4, the state encodings EMPTY=0/PEND=1, and mode encodings RR=0/FIXED=1.
REQ-031 The rotating first-ready search is a sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs grant_idx[1:0], any); it is purely combinational.

Verification
REQ-032 RR, all out_ready=1, stream 0x1,0x2,0x3,0x4,0x5 back-to-back -> out_valid sequence 0001,0010,0100,1000,0001; data matches; disp_cnt=5.
REQ-033 RR, ptr=1, out_ready=0101, word 0xA -> dispatch to ch2, sel=2, out2=0xA, out0/1/3=0.
REQ-034 FIXED, cfg_ch=3, out_ready[3]=0 for 10 cycles then 1, word 0x7 -> in_ready=0 throughout the stall, single strobe on ch3 with 0x7, then in_ready=1.
REQ-035 Stall then simultaneous event: PEND, out_ready rises same cycle in_valid=1 -> dispatch and accept same cycle, state stays PEND, no word lost.
REQ-036 rst_n=0 asserted while PEND holding 0xC -> no strobe, all outputs 0, disp_cnt=0.
REQ-037 256 dispatches from disp_cnt=0 -> disp_cnt wraps to 0.
